// File: rtl/data_mem_unit_pkg.sv
// Purpose: shared FSM state encoding, default data width and request check helper for data_mem_unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package data_mem_unit_pkg;

  // Access FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DMU_DATA_W = 16;

  // A request is rejected when the byte address is odd, the word index is past the
  // end of the RAM, or LW and SW are asserted together.
  function automatic logic req_is_bad(input logic misaligned,
                                      input logic out_of_range,
                                      input logic rd,
                                      input logic wr);
    return misaligned | out_of_range | (rd & wr);
  endfunction

endpackage

// File: rtl/data_mem_unit_sram_1p.sv
// Purpose: single-port synchronous word RAM backing the data-memory stage.
// Latency: one cycle from en (we=0) to dout; writes land on the same edge.
// Backpressure: none; accepts an access every cycle.
// Ports: clock; we/en access strobes; idx word index; din write data; dout registered read data.
// Contents and dout are not reset.
module sram_1p
  import data_mem_unit_pkg::*;
#(
  parameter int DW    = DMU_DATA_W,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic          en,
  input  logic [AW-1:0] idx,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  // dout keeps its last read value during a write cycle.
  always_ff @(posedge clock) begin
    if (en) begin
      if (we) begin
        mem[idx] <= din;
      end else begin
        dout <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Purpose: multi-cycle LW/SW data-memory stage between the execute ALU and write-back.
// Latency: valid access -> done LATENCY+1 cycles after the request; rejected access -> done next cycle.
// Backpressure: stall held from the request cycle through BUSY; requests are ignored in BUSY and DONE.
// Ports: clock, reset_n (async, active low); mem_read/mem_write request strobes; addr byte address;
//        wdata store data; rdata registered load data; stall hold-PC (comb); done/err completion pulses.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DATA_W  = DMU_DATA_W,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counter only ever holds LATENCY-1 down to 0.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("data_mem_unit: LATENCY must be >= 1");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_wr_q, is_wr_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_idx;
  logic [DATA_W-1:0] ram_dout;

  // Word index kept at full width so large addresses are rejected rather than wrapped.
  logic [31:0]   word_idx;
  logic [AW-1:0] req_idx;
  logic          req, req_bad;

  assign word_idx = 32'(addr[DATA_W-1:1]);
  assign req_idx  = word_idx[AW-1:0];
  assign req      = mem_read | mem_write;
  assign req_bad  = req_is_bad(addr[0], word_idx >= 32'(DEPTH), mem_read, mem_write);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    is_wr_d = is_wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    ram_en  = 1'b0;
    ram_we  = 1'b0;
    ram_idx = idx_q;
    stall   = 1'b0;
    done    = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        stall   = req;
        ram_idx = req_idx;
        if (req) begin
          if (req_bad) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ST_BUSY;
            cnt_d   = CW'(LATENCY - 1);
            idx_d   = req_idx;
            wdata_d = wdata;
            is_wr_d = mem_write;
            err_d   = 1'b0;
            // Start the read now so dout is ready even when LATENCY is 1.
            ram_en  = mem_read;
          end
        end
      end
      ST_BUSY: begin
        stall  = 1'b1;
        // Keep re-reading the latched index; the final cycle sees a fresh dout.
        ram_en = 1'b1;
        if (cnt_q == '0) begin
          ram_we  = is_wr_q;
          if (!is_wr_q) begin
            rdata_d = ram_dout;
          end
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // PC must not be held while the stage is in reset.
    stall = stall & reset_n;
  end

  assign rdata = rdata_q;

  sram_1p #(
    .DW   (DATA_W),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_sram (
    .clock(clock),
    .we   (ram_we),
    .en   (ram_en),
    .idx  (ram_idx),
    .din  (wdata_q),
    .dout (ram_dout)
  );

endmodule

// File: tb/tb_data_mem_unit.sv
// Purpose: self-checking bench for data_mem_unit (LATENCY=2, DEPTH=256).
// Latency: n/a.
// Backpressure: n/a.
module tb_data_mem_unit;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic        clock     = 1'b0;
  logic        reset_n   = 1'b0;
  logic        mem_read  = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] addr      = '0;
  logic [15:0] wdata     = '0;
  logic [15:0] rdata;
  logic        stall, done, err;

  data_mem_unit #(
    .DATA_W (16),
    .DEPTH  (DEPTH),
    .LATENCY(LAT)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .stall    (stall),
    .done     (done),
    .err      (err)
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference model: word array plus the last successfully loaded value.
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] ref_rdata = '0;

  task automatic model_apply(input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] wd, output int lat, output logic e,
                             output logic [15:0] rdv);
    int widx;
    bit bad;
    widx = int'(a) / 2;
    bad  = (a % 16'd2 != 16'd0) || (widx >= DEPTH) || (rd && wr);
    if (!bad) begin
      if (wr) ref_mem[widx] = wd;
      if (rd) ref_rdata = ref_mem[widx];
    end
    lat = bad ? 1 : LAT + 1;
    e   = bad;
    rdv = ref_rdata;
  endtask

  task automatic clear_inputs();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    addr      = '0;
    wdata     = '0;
  endtask

  // Issues one request in the cycle after the next posedge and follows it to done.
  // With garble set, inputs are randomised every cycle after the request cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] wd, input bit garble,
                           output int lat, output logic e, output logic [15:0] rdv,
                           output int stalls, output logic stall_at_done);
    @(posedge clock); #1;
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    @(negedge clock);
    stalls        = stall ? 1 : 0;
    lat           = 0;
    e             = 1'b0;
    rdv           = rdata;
    stall_at_done = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (garble) begin
        mem_read  = 1'($urandom);
        mem_write = 1'($urandom);
        addr      = 16'($urandom);
        wdata     = 16'($urandom);
      end else begin
        clear_inputs();
      end
      @(negedge clock);
      if (done) begin
        lat           = k;
        e             = err;
        rdv           = rdata;
        stall_at_done = stall;
        break;
      end
      if (stall) stalls++;
    end
    clear_inputs();
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] wd;
    logic        exp_err;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] wd, input logic e, input logic [15:0] r,
                         input int l);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.wd = wd;
    v.exp_err = e; v.exp_rdata = r; v.exp_lat = l;
    vecs.push_back(v);
  endtask

  int          g_lat, m_lat, g_stalls;
  logic        g_err, m_err, g_sdone;
  logic [15:0] g_rd, m_rd;

  initial begin
    //            rd wr addr      wdata     err rdata     lat
    add_vec(1'b0, 1'b1, 16'h0010, 16'h00AB, 1'b0, 16'h0000, 3);
    add_vec(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h00AB, 3);
    add_vec(1'b1, 1'b0, 16'h0011, 16'h0000, 1'b1, 16'h00AB, 1);
    add_vec(1'b1, 1'b0, 16'h0200, 16'h0000, 1'b1, 16'h00AB, 1);
    add_vec(1'b0, 1'b1, 16'h0004, 16'h7777, 1'b0, 16'h00AB, 3);
    add_vec(1'b1, 1'b1, 16'h0004, 16'hDEAD, 1'b1, 16'h00AB, 1);
    add_vec(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h7777, 3);
    add_vec(1'b0, 1'b1, 16'h0020, 16'h0BEE, 1'b0, 16'h7777, 3);
    add_vec(1'b0, 1'b1, 16'h0002, 16'h5555, 1'b0, 16'h7777, 3);
    add_vec(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h5555, 3);
    add_vec(1'b0, 1'b1, 16'hFFFE, 16'h1111, 1'b1, 16'h5555, 1);
    add_vec(1'b0, 1'b1, 16'h01FE, 16'h2222, 1'b0, 16'h5555, 3);
    add_vec(1'b1, 1'b0, 16'h01FE, 16'h0000, 1'b0, 16'h2222, 3);
    add_vec(1'b0, 1'b1, 16'h0201, 16'h3333, 1'b1, 16'h2222, 1);
    add_vec(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h00AB, 3);
    add_vec(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0BEE, 3);

    // Reset: a request held during reset must not raise stall.
    reset_n  = 1'b0;
    mem_read = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_rdata", 32'(rdata), 32'h0);
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_done",  32'(done),  32'h0);
    check("reset_err",   32'(err),   32'h0);
    mem_read = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("idle_rdata", 32'(rdata), 32'h0);
    check("idle_stall", 32'(stall), 32'h0);
    check("idle_done",  32'(done),  32'h0);
    check("idle_err",   32'(err),   32'h0);

    // Directed table, issued back-to-back with inputs scrambled while BUSY/DONE.
    foreach (vecs[i]) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, 1'b1,
                g_lat, g_err, g_rd, g_stalls, g_sdone);
      model_apply(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, m_lat, m_err, m_rd);
      check($sformatf("vec%0d_latency", i), 32'(g_lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), 32'(g_rd), 32'(vecs[i].exp_rdata));
      check($sformatf("vec%0d_stall_cycles", i), 32'(g_stalls), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_stall_at_done", i), 32'(g_sdone), 32'h0);
    end

    // done is a single-cycle pulse and the stage is idle afterwards.
    @(negedge clock);
    check("done_pulse_width", 32'(done), 32'h0);
    check("post_done_stall",  32'(stall), 32'h0);

    // Reset during BUSY aborts a store.
    @(posedge clock); #1;
    mem_write = 1'b1;
    addr      = 16'h0020;
    wdata     = 16'h1234;
    @(negedge clock);
    check("abort_req_stall", 32'(stall), 32'h1);
    @(posedge clock); #1;
    clear_inputs();
    #1 reset_n = 1'b0;
    #1;
    check("abort_rst_stall", 32'(stall), 32'h0);
    check("abort_rst_done",  32'(done),  32'h0);
    check("abort_rst_rdata", 32'(rdata), 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    ref_rdata = '0;
    do_access(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, g_lat, g_err, g_rd, g_stalls, g_sdone);
    model_apply(1'b1, 1'b0, 16'h0020, 16'h0000, m_lat, m_err, m_rd);
    check("abort_load_rdata",   32'(g_rd),  32'h0BEE);
    check("abort_load_latency", 32'(g_lat), 32'(LAT + 1));
    check("abort_load_err",     32'(g_err), 32'h0);

    // Random phase: seed a 16-word window, then mixed traffic against the model.
    for (int w = 0; w < 16; w++) begin
      logic [15:0] a, d;
      a = 16'h0100 + 16'(2 * w);
      d = 16'($urandom);
      do_access(1'b0, 1'b1, a, d, 1'b1, g_lat, g_err, g_rd, g_stalls, g_sdone);
      model_apply(1'b0, 1'b1, a, d, m_lat, m_err, m_rd);
      check($sformatf("seed%0d_latency", w), 32'(g_lat), 32'(m_lat));
      check($sformatf("seed%0d_err", w), 32'(g_err), 32'(m_err));
    end

    for (int n = 0; n < 60; n++) begin
      logic        rd, wr;
      logic [15:0] a, d;
      int          kind, gap;
      kind = $urandom_range(0, 9);
      rd   = 1'($urandom);
      wr   = ~rd;
      a    = 16'h0100 + 16'(2 * $urandom_range(0, 15));
      d    = 16'($urandom);
      if (kind == 7) a = a | 16'h0001;
      if (kind == 8) a = 16'($urandom_range(16'h0200, 16'hFFFF)) & 16'hFFFE;
      if (kind == 9) begin rd = 1'b1; wr = 1'b1; end
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clock);
      do_access(rd, wr, a, d, 1'b1, g_lat, g_err, g_rd, g_stalls, g_sdone);
      model_apply(rd, wr, a, d, m_lat, m_err, m_rd);
      check($sformatf("rnd%0d_latency", n), 32'(g_lat), 32'(m_lat));
      check($sformatf("rnd%0d_err", n), 32'(g_err), 32'(m_err));
      check($sformatf("rnd%0d_rdata", n), 32'(g_rd), 32'(m_rd));
      check($sformatf("rnd%0d_stall_cycles", n), 32'(g_stalls), 32'(m_lat));
      check($sformatf("rnd%0d_stall_at_done", n), 32'(g_sdone), 32'h0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
